// File: rtl/gf16_horner_compressor.sv
// GF(2^4) Horner compressor: packs raw RO bits into nibbles, folds BLOCK_LEN
// nibbles per word. Optional stuck-source detector under `STUCK_DETECT_EN.

module gf16_mul2_stage (
  input  logic [3:0] i_a,
  output logic [3:0] o_y
);
  // multiply by x modulo x^4+x+1
  assign o_y = {i_a[2:0], 1'b0} ^ {2'b00, i_a[3], i_a[3]};
endmodule

module gf16_horner_compressor #(
  parameter int BLOCK_LEN   = 8,
  parameter int STUCK_LIMIT = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BIT_IN,
  input  logic       BIT_VALID,
  output logic [3:0] D_OUT,
  output logic       D_VALID,
  input  logic       D_READY,
  output logic       DROP,
  output logic       ERR
);

  if (BLOCK_LEN < 1 || BLOCK_LEN > 255 ||
      STUCK_LIMIT < 2 || STUCK_LIMIT > 255) begin : g_bad_param
    $error("gf16_horner_compressor: parameter out of range");
  end

  localparam logic [7:0] LAST = 8'(BLOCK_LEN - 1);

  typedef enum logic {S_EMPTY, S_FULL} st_t;

  st_t        r_state;
  st_t        w_state_nxt;
  logic [2:0] r_sh;
  logic [1:0] r_bcnt;
  logic [3:0] r_acc;
  logic [7:0] r_ncnt;
  logic [3:0] r_dout;
  logic       r_drop;

  logic [3:0] w_nib;
  logic [3:0] w_mul;
  logic [3:0] w_next;
  logic       w_take;
  logic       w_trip;
  logic       w_hold;
  logic       w_nib_done;
  logic       w_complete;
  logic       w_load;
  logic       w_drop_set;

  assign w_nib  = {r_sh, BIT_IN};
  assign w_next = w_mul ^ w_nib;

  gf16_mul2_stage u_mul2 (
    .i_a (r_acc),
    .o_y (w_mul)
  );

  assign w_take     = BIT_VALID & ~w_hold;
  assign w_nib_done = w_take & ~w_trip & (r_bcnt == 2'd3);
  assign w_complete = w_nib_done & (r_ncnt == LAST);

`ifdef STUCK_DETECT_EN
  logic [7:0] r_run;
  logic       r_prev;
  logic       r_err;
  logic [7:0] w_run_nxt;

  // run length of identical accepted bits; 0 means no bit seen yet
  always_comb begin
    w_run_nxt = 8'd1;
    if (r_run != 8'd0 && BIT_IN == r_prev)
      w_run_nxt = (r_run == 8'hFF) ? r_run : r_run + 8'd1;
  end

  assign w_trip = w_take & (w_run_nxt == 8'(STUCK_LIMIT));
  assign w_hold = r_err;
  assign ERR    = r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_run  <= 8'd0;
      r_prev <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_take) begin
      r_run  <= w_run_nxt;
      r_prev <= BIT_IN;
      if (w_trip)
        r_err <= 1'b1;
    end
  end
`else
  assign w_trip = 1'b0;
  assign w_hold = 1'b0;
  assign ERR    = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sh   <= 3'd0;
      r_bcnt <= 2'd0;
      r_acc  <= 4'd0;
      r_ncnt <= 8'd0;
    end else if (w_trip) begin
      r_sh   <= 3'd0;
      r_bcnt <= 2'd0;
      r_acc  <= 4'd0;
      r_ncnt <= 8'd0;
    end else if (w_take) begin
      r_sh   <= w_nib[2:0];
      r_bcnt <= r_bcnt + 2'd1;
      if (r_bcnt == 2'd3) begin
        if (r_ncnt == LAST) begin
          r_acc  <= 4'd0;
          r_ncnt <= 8'd0;
        end else begin
          r_acc  <= w_next;
          r_ncnt <= r_ncnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_state <= S_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: if (w_complete) w_state_nxt = S_FULL;
      S_FULL:  if (D_READY && !w_complete) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // a same-edge handshake frees the slot, so the new word replaces it
  always_comb begin
    w_load     = w_complete & ((r_state == S_EMPTY) | D_READY);
    w_drop_set = w_complete & (r_state == S_FULL) & ~D_READY;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dout <= 4'd0;
      r_drop <= 1'b0;
    end else begin
      if (w_load)
        r_dout <= w_next;
      if (w_drop_set)
        r_drop <= 1'b1;
    end
  end

  assign D_OUT   = r_dout;
  assign D_VALID = (r_state == S_FULL);
  assign DROP    = r_drop;

endmodule

// File: tb/tb_gf16_horner_compressor.sv
// Scoreboard bench: two instances (BLOCK_LEN 1 and 2) share one bit stream
// and are checked against a GF(16) polynomial reference model.

module tb_gf16_horner_compressor;

  localparam int SL = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BIT_IN;
  logic       BIT_VALID;
  logic       RDY1, RDY2;
  logic [3:0] D1, D2;
  logic       V1, V2, DR1, DR2, E1, E2;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  always #5 CLK = ~CLK;

  gf16_horner_compressor #(.BLOCK_LEN(1), .STUCK_LIMIT(SL)) u1 (
    .CLK(CLK), .RST(RST), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
    .D_OUT(D1), .D_VALID(V1), .D_READY(RDY1), .DROP(DR1), .ERR(E1)
  );

  gf16_horner_compressor #(.BLOCK_LEN(2), .STUCK_LIMIT(SL)) u2 (
    .CLK(CLK), .RST(RST), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
    .D_OUT(D2), .D_VALID(V2), .D_READY(RDY2), .DROP(DR2), .ERR(E2)
  );

  int         LEN [2] = '{1, 2};
  logic [3:0] m_cur;
  int         m_bc;
  logic [3:0] m_nib [2][4];
  int         m_nc [2];
  logic       m_full [2];
  logic       m_drop [2];
  int         m_run;
  logic       m_prev;
  logic       m_err;
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] xpow(input int e);
    logic [3:0] r;
    r = 4'd1;
    for (int i = 0; i < e; i++) r = gmul(r, 4'd2);
    return r;
  endfunction

  // word = sum over nibbles n_k * x^(L-1-k)
  function automatic logic [3:0] blk_word(input int i);
    logic [3:0] w;
    w = 4'd0;
    for (int k = 0; k < LEN[i]; k++)
      w = w ^ gmul(m_nib[i][k], xpow(LEN[i] - 1 - k));
    return w;
  endfunction

  task automatic model_clear();
    m_cur = 4'd0; m_bc = 0; m_run = 0; m_prev = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_nc[i] = 0; m_full[i] = 1'b0; m_drop[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_edge(input bit b, input bit v, input bit r0, input bit r1);
    bit trip, nd, comp, r;
    logic [3:0] w;
    trip = 0; nd = 0;
    if (v && !m_err) begin
`ifdef STUCK_DETECT_EN
      if (m_run == 0 || b != m_prev) m_run = 1;
      else m_run++;
      m_prev = b;
      if (m_run == SL) begin
        trip = 1; m_err = 1'b1; m_bc = 0; m_cur = 4'd0;
        m_nc[0] = 0; m_nc[1] = 0;
      end
`endif
      if (!trip) begin
        m_cur = {m_cur[2:0], b};
        m_bc++;
        if (m_bc == 4) begin m_bc = 0; nd = 1; end
      end
    end
    for (int i = 0; i < 2; i++) begin
      comp = 0; w = 4'd0;
      r = (i == 0) ? r0 : r1;
      if (nd) begin
        m_nib[i][m_nc[i]] = m_cur;
        m_nc[i]++;
        if (m_nc[i] == LEN[i]) begin
          comp = 1; w = blk_word(i); m_nc[i] = 0;
        end
      end
      if (comp) begin
        if (!m_full[i] || r) begin
          if (i == 0) q0.push_back(w); else q1.push_back(w);
          m_full[i] = 1'b1;
        end else
          m_drop[i] = 1'b1;
      end else if (m_full[i] && r)
        m_full[i] = 1'b0;
    end
  endtask

  task automatic step(input bit b, input bit v, input bit r0, input bit r1);
    BIT_IN = b; BIT_VALID = v; RDY1 = r0; RDY2 = r1;
    @(posedge CLK);
    model_edge(b, v, r0, r1);
    #1;
  endtask

  task automatic do_reset();
    BIT_VALID = 1'b0; BIT_IN = 1'b0;
    RST = 1'b1;
    #2;
    chk("rst_dout1", D1, 0);  chk("rst_dout2", D2, 0);
    chk("rst_v1", V1, 0);     chk("rst_v2", V2, 0);
    chk("rst_drop1", DR1, 0); chk("rst_drop2", DR2, 0);
    chk("rst_err1", E1, 0);   chk("rst_err2", E2, 0);
    model_clear();
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic feed(input logic [7:0] bits, input int n, input bit r0, input bit r1);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, r0, r1);
  endtask

  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      chk("valid1", V1, m_full[0]);
      chk("drop1", DR1, m_drop[0]);
      chk("err1", E1, m_err);
      if (V1 && RDY1) begin
        if (q0.size() == 0) chk("word1_unexpected", 1, 0);
        else chk("word1", D1, q0.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      chk("valid2", V2, m_full[1]);
      chk("drop2", DR2, m_drop[1]);
      chk("err2", E2, m_err);
      if (V2 && RDY2) begin
        if (q1.size() == 0) chk("word2_unexpected", 1, 0);
        else chk("word2", D2, q1.pop_front());
      end
    end
  end

  initial begin
    RST = 1'b1; BIT_IN = 1'b0; BIT_VALID = 1'b0; RDY1 = 1'b0; RDY2 = 1'b0;
    model_clear();
    @(posedge CLK);
    #1;
    do_reset();
    mon_en = 1;

    feed(8'b1011, 4, 1'b1, 1'b1);
    chk("l1_first_v", V1, 1);
    chk("l1_first_dout", D1, 4'hB);

    do_reset();
    feed(8'b10010101, 8, 1'b1, 1'b1);
    chk("l2_word_v", V2, 1);
    chk("l2_word_dout", D2, 4'h4);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("l2_word_gone", V2, 0);

    do_reset();
    feed(8'b10110011, 8, 1'b0, 1'b0);
    chk("drop_dout", D1, 4'hB);
    chk("drop_flag", DR1, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("drop_consumed_v", V1, 0);
    chk("drop_sticky", DR1, 1);

    do_reset();
    feed(8'b10110001, 7, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("swap_dout", D1, 4'h3);
    chk("swap_v", V1, 1);
    chk("swap_nodrop", DR1, 0);

    do_reset();
    feed(8'b101100, 6, 1'b0, 1'b0);
    chk("pre_rst_v1", V1, 1);
    do_reset();
    feed(8'b10010101, 8, 1'b1, 1'b1);
    chk("post_rst_dout2", D2, 4'h4);

`ifdef STUCK_DETECT_EN
    do_reset();
    feed(8'hFF, 8, 1'b1, 1'b1);
    chk("stuck_err", E2, 1);
    chk("stuck_noword", V2, 0);
    feed(8'b10101010, 8, 1'b1, 1'b1);
    chk("stuck_ignored", V2, 0);
`endif

    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 499) do_reset();
      step(1'($urandom), ($urandom % 5) != 0,
           ($urandom % 3) != 0, ($urandom % 3) != 0);
    end

    @(negedge CLK);
    mon_en = 0;
    chk("q0_left", 8'(q0.size()), m_full[0] ? 1 : 0);
    chk("q1_left", 8'(q1.size()), m_full[1] ? 1 : 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf16_horner_compressor.md
# gf16_horner_compressor

Post-processing stage that consumes the raw ring-oscillator sampler bit stream and compresses it into 4-bit output words. It packs raw bits into nibbles and folds every BLOCK_LEN nibbles into one GF(2^4) value using Horner's rule. Field: polynomial x^4+x+1; the multiply-by-x step is the team's existing MUL2 stage, instantiated here. The block sits between the RO sampler and the output FIFO/UART path. It presents results through a one-deep valid/ready output register.

## Interface
- BLOCK_LEN, 8: nibbles folded per output word; legal range 1..255.
- STUCK_LIMIT, 32: consecutive identical accepted raw bits that trip the stuck detector; legal range 2..255. Used only with STUCK_DETECT_EN.
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  reset, asynchronous, active-high.
- BIT_IN  input  1  raw random bit from the sampler.
- BIT_VALID  input  1  BIT_IN is accepted on each rising edge where this is 1. The stream cannot be stalled.
- D_OUT  output  4  compressed word; stable while D_VALID=1.
- D_VALID  output  1  D_OUT holds an unconsumed word.
- D_READY  input  1  consumer accepts D_OUT on an edge where D_VALID=1 and D_READY=1.
- DROP  output  1  sticky: a completed word was discarded because the output register was occupied.
- ERR  output  1  sticky stuck-source flag; tied 0 without STUCK_DETECT_EN.

## Operation
- Reset values (asynchronous): shift register 0, bit count 0, accumulator 0, nibble count 0, D_OUT=0, D_VALID=0, DROP=0, ERR=0, run counter 0.
- Bit packing:
  - On each accepted bit, sh <= {sh[2:0], BIT_IN}, MSB first, and the bit count increments mod 4.
  - The 4th accepted bit forms nib = {sh[2:0], BIT_IN}.
- Horner fold, on the cycle a nibble forms:
  - next = MUL2(acc) ^ nib.
  - If nibble count < BLOCK_LEN-1: acc <= next, nibble count +1.
  - Otherwise the block completes: acc <= 0, nibble count <= 0, and next is offered to the output register.
- Output register states:
  - EMPTY (D_VALID=0): a completed block loads D_OUT <= next and moves to FULL.
  - FULL (D_VALID=1): a handshake (D_READY=1) moves to EMPTY.
  - Completion while FULL with D_READY=1 on the same edge: D_OUT reloads with the new word, D_VALID stays 1, and nothing is dropped.
  - Completion while FULL with D_READY=0: the new word is discarded, DROP <= 1, and D_OUT and D_VALID are unchanged.
- DROP and ERR clear only on RST.
- BIT_VALID=0: all fold state holds.
- Wrap-around: counters return to 0 exactly at a nibble boundary (bit count) and a block boundary (nibble count). There is no partial-block flush.
- Reset mid-block: the partial nibble, the accumulator and any pending output are lost.

## Timing
- Latency: the 4th bit of the last nibble is accepted on edge k; D_VALID=1 and D_OUT are valid after edge k.
- All outputs are registered. There is no combinational path from D_READY to any output.
- Throughput: one word per 4*BLOCK_LEN accepted bits. One bit is accepted per cycle at most.
- D_OUT never changes while D_VALID=1 and D_READY=0.

## Configuration
- Macro: STUCK_DETECT_EN.
- Defined:
  - The run counter increments when an accepted bit equals the previous accepted bit. It resets to 1 when the bit differs. The first bit after reset sets it to 1.
  - When the counter reaches STUCK_LIMIT, the following happen on that edge:
    - ERR <= 1.
    - The shift register, bit count, accumulator and nibble count clear.
    - The word in progress is discarded.
  - While ERR=1, no new words complete and bits are ignored.
  - A word already in D_OUT remains available until handshaked.
- Undefined: no run counter; ERR is constant 0.

## Test plan
- BLOCK_LEN=1: bits 1,0,1,1 on consecutive cycles with D_READY=1 -> D_VALID=1 after the 4th edge with D_OUT=4'hB.
- BLOCK_LEN=2: nibbles 1001 then 0101 -> D_OUT=4'h4, since MUL2(4'h9)=4'h1 and 4'h1^4'h5=4'h4. Exactly one D_VALID pulse when D_READY=1.
- BLOCK_LEN=1, D_READY=0: feed 8 bits 1,0,1,1,0,0,1,1 -> D_OUT stays 4'hB and DROP=1. Then raise D_READY -> the word is consumed, D_VALID=0, DROP stays 1.
- BLOCK_LEN=1: the second word completes on the same edge that the first is handshaked -> D_OUT updates to the second word, D_VALID stays 1, DROP=0.
- STUCK_DETECT_EN, STUCK_LIMIT=8: feed 8 consecutive 1s -> ERR=1 after the 8th edge and no word is produced. Further alternating bits -> no D_VALID. Assert RST -> ERR=0.
- Assert RST after 6 bits of a BLOCK_LEN=2 block -> all outputs are 0 immediately. The next 8 bits 1001,0101 give D_OUT=4'h4.
